// File: rtl/mixer_frame_scheduler_pkg.sv
// Shared types, widths and result scaling for the mixer frame scheduler.
// Optional feature macro: MIXER_SCHED_SAT_EN (saturate instead of wrap).
package mixer_sched_pkg;

    localparam int unsigned DATA_WIDTH   = 24;
    localparam int unsigned DOUT_W       = 16;
    localparam int unsigned MULT_W       = DOUT_W + DATA_WIDTH;
    localparam int unsigned MULT_LAT_DEF = 2;
    localparam int unsigned OVR_CNT_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_L,
        ISSUE_R,
        DRAIN,
        OUT
    } state_t;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [DOUT_W-1:0]     osc_t;
    typedef logic signed [MULT_W-1:0]     prod_t;

    localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Rescale a Q1.15 x sample product back to sample width (floor shift).
    function automatic sample_t sat_trunc(input prod_t p);
        prod_t s;
        s = p >>> (DOUT_W - 1);
`ifdef MIXER_SCHED_SAT_EN
        if (s > prod_t'(SAMPLE_MAX)) begin
            return SAMPLE_MAX;
        end
        if (s < prod_t'(SAMPLE_MIN)) begin
            return SAMPLE_MIN;
        end
        return s[DATA_WIDTH-1:0];
`else
        return s[DATA_WIDTH-1:0];
`endif
    endfunction

endpackage

// File: rtl/mixer_frame_scheduler_if.sv
// Handshake/data bundle between upstream, the scheduler and downstream.
interface mixer_frame_scheduler_if;
    import mixer_sched_pkg::*;

    logic                 i_frame_tick;
    logic                 i_valid;
    logic                 o_ready;
    sample_t              i_signal_left;
    sample_t              i_signal_right;
    osc_t                 i_osc;
    logic                 o_osc_en;
    sample_t              o_converted_left;
    sample_t              o_converted_right;
    logic                 o_valid;
    logic                 i_ready;
    logic [OVR_CNT_W-1:0] o_overrun_cnt;

    modport master (
        output i_frame_tick, i_valid, i_signal_left, i_signal_right, i_osc, i_ready,
        input  o_ready, o_osc_en, o_converted_left, o_converted_right, o_valid, o_overrun_cnt
    );

    modport slave (
        input  i_frame_tick, i_valid, i_signal_left, i_signal_right, i_osc, i_ready,
        output o_ready, o_osc_en, o_converted_left, o_converted_right, o_valid, o_overrun_cnt
    );

endinterface

// File: rtl/mixer_frame_scheduler_mult_pipe.sv
// Shared signed multiplier, MULT_LAT register stages, channel tag alongside.
module mixer_mult_pipe
    import mixer_sched_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    input  logic    in_tag,
    input  osc_t    in_a,
    input  sample_t in_b,
    output logic    out_valid,
    output logic    out_tag,
    output prod_t   out_p
);

    prod_t p_q [MULT_LAT];
    prod_t p_d [MULT_LAT];
    logic  v_q [MULT_LAT];
    logic  v_d [MULT_LAT];
    logic  t_q [MULT_LAT];
    logic  t_d [MULT_LAT];

    // Stage 0 takes the fresh product; later stages shift the previous one.
    always_comb begin
        p_d[0] = prod_t'(in_a) * prod_t'(in_b);
        v_d[0] = in_valid;
        t_d[0] = in_tag;
        for (int unsigned i = 1; i < MULT_LAT; i++) begin
            p_d[i] = p_q[i-1];
            v_d[i] = v_q[i-1];
            t_d[i] = t_q[i-1];
        end
    end

    // Pipeline registers, cleared on reset so no stale product survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                p_q[i] <= '0;
                v_q[i] <= 1'b0;
                t_q[i] <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                p_q[i] <= p_d[i];
                v_q[i] <= v_d[i];
                t_q[i] <= t_d[i];
            end
        end
    end

    assign out_valid = v_q[MULT_LAT-1];
    assign out_tag   = t_q[MULT_LAT-1];
    assign out_p     = p_q[MULT_LAT-1];

endmodule

// File: rtl/mixer_frame_scheduler.sv
// Per-frame mixing scheduler: one shared multiplier, left then right.
// Optional feature macro: MIXER_SCHED_SAT_EN (see package).
module mixer_frame_scheduler
    import mixer_sched_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF
) (
    input  logic                    mclk,
    input  logic                    reset,
    mixer_frame_scheduler_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MULT_LAT + 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    sample_t              left_q, left_d, right_q, right_d;
    osc_t                 osc_q, osc_d;
    sample_t              hold_l_q, hold_l_d;
    sample_t              out_l_q, out_l_d, out_r_q, out_r_d;
    logic                 valid_q, valid_d;
    logic                 osc_en_q, osc_en_d;
    logic [OVR_CNT_W-1:0] ovr_q, ovr_d;

    logic    ready, accept, overrun;
    logic    m_valid, m_tag, p_valid, p_tag;
    sample_t m_b;
    prod_t   p_out;

    mixer_mult_pipe #(.MULT_LAT(MULT_LAT)) u_mult (
        .clk       (mclk),
        .rst_n     (reset),
        .in_valid  (m_valid),
        .in_tag    (m_tag),
        .in_a      (osc_q),
        .in_b      (m_b),
        .out_valid (p_valid),
        .out_tag   (p_tag),
        .out_p     (p_out)
    );

    // Handshake, capture, overrun accounting and frame sequencing.
    always_comb begin
        ready    = (state_q == IDLE) && !valid_q;
        accept   = bus.i_frame_tick && bus.i_valid && ready;
        overrun  = bus.i_frame_tick && bus.i_valid && !ready;
        state_d  = state_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        right_d  = right_q;
        osc_d    = osc_q;
        hold_l_d = hold_l_q;
        out_l_d  = out_l_q;
        out_r_d  = out_r_q;
        valid_d  = valid_q;
        osc_en_d = bus.i_frame_tick;
        ovr_d    = ovr_q;
        m_valid  = 1'b0;
        m_tag    = 1'b0;
        m_b      = left_q;

        if (accept) begin
            left_d  = bus.i_signal_left;
            right_d = bus.i_signal_right;
            osc_d   = bus.i_osc;
        end
        if (overrun && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVR_CNT_W'(1);
        end
        if (p_valid && !p_tag) begin
            hold_l_d = sat_trunc(p_out);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE_L;
                end
            end
            ISSUE_L: begin
                m_valid = 1'b1;
                state_d = ISSUE_R;
            end
            ISSUE_R: begin
                m_valid = 1'b1;
                m_tag   = 1'b1;
                m_b     = right_q;
                cnt_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                // Right product leaves the pipe in the final drain cycle, so it
                // is taken straight from the pipe while left comes from its hold.
                if (cnt_q == CNT_W'(MULT_LAT - 1)) begin
                    out_l_d = hold_l_q;
                    out_r_d = sat_trunc(p_out);
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            osc_q    <= '0;
            hold_l_q <= '0;
            out_l_q  <= '0;
            out_r_q  <= '0;
            valid_q  <= 1'b0;
            osc_en_q <= 1'b0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            right_q  <= right_d;
            osc_q    <= osc_d;
            hold_l_q <= hold_l_d;
            out_l_q  <= out_l_d;
            out_r_q  <= out_r_d;
            valid_q  <= valid_d;
            osc_en_q <= osc_en_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.o_ready           = ready;
    assign bus.o_valid           = valid_q;
    assign bus.o_osc_en          = osc_en_q;
    assign bus.o_converted_left  = out_l_q;
    assign bus.o_converted_right = out_r_q;
    assign bus.o_overrun_cnt     = ovr_q;

endmodule

// File: tb/tb_mixer_frame_scheduler.sv
// Self-checking bench for mixer_frame_scheduler: directed vectors, corner
// sequences and random traffic against a transaction-level model.
module tb_mixer_frame_scheduler;
    import mixer_sched_pkg::*;

    localparam int unsigned ML = 2;

    logic mclk  = 1'b0;
    logic reset = 1'b1;
    always #5 mclk = ~mclk;

    mixer_frame_scheduler_if ifc();

    mixer_frame_scheduler #(.MULT_LAT(ML)) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct {
        logic [15:0] osc;
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] el;
        logic [23:0] er;
    } vec_t;

    vec_t   vecs [6];
    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    // Transaction model: at most one frame owned between accept and handshake.
    bit          m_infl;
    longint      m_acc;
    logic [23:0] m_l, m_r;
    bit          m_prev_tick;
    int          m_cnt;

    function automatic logic [23:0] mix(input logic [15:0] osc, input logic [23:0] s);
        longint p, r;
        p = longint'($signed(osc)) * longint'($signed(s));
        r = p >>> 15;
`ifdef MIXER_SCHED_SAT_EN
        if (r > 64'sd8388607) r = 64'sd8388607;
        else if (r < -64'sd8388608) r = -64'sd8388608;
`endif
        return r[23:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit tick, input bit vld, input bit rdy,
                         input logic [15:0] osc, input logic [23:0] l, input logic [23:0] r);
        ifc.i_frame_tick   = tick;
        ifc.i_valid        = vld;
        ifc.i_ready        = rdy;
        ifc.i_osc          = osc;
        ifc.i_signal_left  = l;
        ifc.i_signal_right = r;
    endtask

    // Compare this cycle's outputs with the model, advance model, step clock.
    task automatic cycle();
        bit er, ev;
        er = !m_infl;
        ev = m_infl && (cyc >= m_acc + longint'(3 + ML));
        chk("o_ready", {63'd0, ifc.o_ready}, {63'd0, er});
        chk("o_valid", {63'd0, ifc.o_valid}, {63'd0, ev});
        chk("o_osc_en", {63'd0, ifc.o_osc_en}, {63'd0, m_prev_tick});
        chk("o_overrun_cnt", {56'd0, ifc.o_overrun_cnt}, 64'(m_cnt));
        if (ev) begin
            chk("o_converted_left", {40'd0, ifc.o_converted_left}, {40'd0, m_l});
            chk("o_converted_right", {40'd0, ifc.o_converted_right}, {40'd0, m_r});
            if (ifc.i_ready) m_infl = 1'b0;
        end
        if (ifc.i_frame_tick && ifc.i_valid) begin
            if (er) begin
                m_infl = 1'b1;
                m_acc  = cyc;
                m_l    = mix(ifc.i_osc, ifc.i_signal_left);
                m_r    = mix(ifc.i_osc, ifc.i_signal_right);
            end else if (m_cnt != 255) begin
                m_cnt++;
            end
        end
        m_prev_tick = ifc.i_frame_tick;
        @(posedge mclk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b0;
        #1;
        chk("rst_o_valid", {63'd0, ifc.o_valid}, 64'd0);
        chk("rst_o_ready", {63'd0, ifc.o_ready}, 64'd1);
        chk("rst_ovr_cnt", {56'd0, ifc.o_overrun_cnt}, 64'd0);
        chk("rst_osc_en", {63'd0, ifc.o_osc_en}, 64'd0);
        chk("rst_out_left", {40'd0, ifc.o_converted_left}, 64'd0);
        m_infl = 1'b0;
        m_cnt = 0;
        m_prev_tick = 1'b0;
        repeat (2) begin
            @(posedge mclk);
            #1;
            cyc++;
        end
        reset = 1'b1;
    endtask

    // One accepted frame with an immediately-ready sink; checks latency and data.
    task automatic run_vec(input vec_t v, input int idx);
        longint acc_c;
        bit got;
        drive(1'b1, 1'b1, 1'b1, v.osc, v.l, v.r);
        acc_c = cyc;
        cycle();
        drive(1'b0, 1'b0, 1'b1, 16'($urandom), 24'($urandom), 24'($urandom));
        chk($sformatf("vec%0d_osc_en_T1", idx), {63'd0, ifc.o_osc_en}, 64'd1);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (ifc.o_valid) begin
                got = 1'b1;
                chk($sformatf("vec%0d_latency", idx), 64'(cyc - acc_c), 64'(3 + ML));
                chk($sformatf("vec%0d_left", idx), {40'd0, ifc.o_converted_left}, {40'd0, v.el});
                chk($sformatf("vec%0d_right", idx), {40'd0, ifc.o_converted_right}, {40'd0, v.er});
            end
            cycle();
        end
        if (!got) chk($sformatf("vec%0d_timeout", idx), 64'd0, 64'd1);
    endtask

    initial begin
        int pulses;
        bit got;
        logic [23:0] hl, hr;

        vecs[0] = '{16'h7FFF, 24'h100000, 24'hF00000, 24'h0FFFE0, 24'hF00020};
`ifdef MIXER_SCHED_SAT_EN
        vecs[1] = '{16'h8000, 24'h800000, 24'h000001, 24'h7FFFFF, 24'hFFFFFF};
`else
        vecs[1] = '{16'h8000, 24'h800000, 24'h000001, 24'h800000, 24'hFFFFFF};
`endif
        vecs[2] = '{16'h0000, 24'h123456, 24'hABCDEF, 24'h000000, 24'h000000};
        vecs[3] = '{16'h4000, 24'h000100, 24'hFFFFFF, 24'h000080, 24'hFFFFFF};
        vecs[4] = '{16'h8000, 24'h7FFFFF, 24'h000000, 24'h800001, 24'h000000};
        vecs[5] = '{16'h7FFF, 24'h7FFFFF, 24'h800000, 24'h7FFEFF, 24'h800100};

        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #2;
        apply_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Output held under back-pressure while two more ticks arrive.
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, vecs[0].osc, vecs[0].l, vecs[0].r);
        cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (ifc.o_valid) got = 1'b1;
            else cycle();
        end
        if (!got) chk("hold_timeout", 64'd0, 64'd1);
        hl = vecs[0].el;
        hr = vecs[0].er;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            drive((i == 4) || (i == 12), 1'b1, 1'b0, 16'($urandom), 24'($urandom), 24'($urandom));
            cycle();
            if (ifc.o_osc_en) pulses++;
            chk("hold_left", {40'd0, ifc.o_converted_left}, {40'd0, hl});
            chk("hold_right", {40'd0, ifc.o_converted_right}, {40'd0, hr});
        end
        chk("hold_overrun_cnt", {56'd0, ifc.o_overrun_cnt}, 64'd2);
        chk("hold_osc_pulses", 64'(pulses), 64'd2);
        drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
        repeat (3) cycle();

        // Tick without data: oscillator steps, nothing else happens.
        drive(1'b1, 1'b0, 1'b1, 16'h1234, 24'h111111, 24'h222222);
        cycle();
        drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
        chk("nodata_osc_en", {63'd0, ifc.o_osc_en}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk("nodata_no_valid", {63'd0, ifc.o_valid}, 64'd0);
            cycle();
        end
        chk("nodata_cnt", {56'd0, ifc.o_overrun_cnt}, 64'd2);

        // Reset while the frame sits in DRAIN, then a clean frame.
        drive(1'b1, 1'b1, 1'b1, vecs[5].osc, vecs[5].l, vecs[5].r);
        cycle();
        drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
        repeat (2) cycle();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_no_valid", {63'd0, ifc.o_valid}, 64'd0);
            cycle();
        end
        run_vec(vecs[0], 10);

        // Random traffic against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                  16'($urandom), 24'($urandom), 24'($urandom));
            cycle();
        end

        // Overrun counter saturation.
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'($urandom), 24'($urandom), 24'($urandom));
            cycle();
        end
        chk("ovr_saturate", {56'd0, ifc.o_overrun_cnt}, 64'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
